// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the ARM-subset five-stage pipeline.
// Provides the control-word field indices, the NZCV bit positions, the
// condition-code encodings and the packed control-word struct.
package pipe_pkg;

  // Bit positions inside the 9-bit control word {WB_EN, MEM_R_EN, MEM_W_EN, EXE_CMD[3:0], B, S}
  localparam int CTRL_WB_EN    = 8;
  localparam int CTRL_MEM_R_EN = 7;
  localparam int CTRL_MEM_W_EN = 6;
  localparam int CTRL_EXE_HI   = 5;
  localparam int CTRL_EXE_LO   = 2;
  localparam int CTRL_B        = 1;
  localparam int CTRL_S        = 0;

  // NZCV bit positions inside the 4-bit status value
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Instruction condition field encodings [31:28]
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Packed control word; member order matches the bit layout above
  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic [3:0] exe_cmd;
    logic       b;
    logic       s;
  } ctrl_t;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluator.
// Ports:
//   cond  - instruction condition field [31:28]
//   flags - {N,Z,C,V} flag view to test against
//   pass  - 1 when the instruction should execute
module cond_check
  import pipe_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = flags[FLAG_N];
  assign w_z = flags[FLAG_Z];
  assign w_c = flags[FLAG_C];
  assign w_v = flags[FLAG_V];

  // NOTE: default assignment before the case keeps this purely combinational (no latch).
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = w_z;
      COND_NE: pass = !w_z;
      COND_CS: pass = w_c;
      COND_CC: pass = !w_c;
      COND_MI: pass = w_n;
      COND_PL: pass = !w_n;
      COND_VS: pass = w_v;
      COND_VC: pass = !w_v;
      COND_HI: pass = w_c && !w_z;
      COND_LS: pass = !w_c || w_z;
      COND_GE: pass = (w_n == w_v);
      COND_LT: pass = (w_n != w_v);
      COND_GT: pass = !w_z && (w_n == w_v);
      COND_LE: pass = w_z || (w_n != w_v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;  // COND_NV
    endcase
  end

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with NZCV status register, condition gating and
// saturating bubble/flush performance counters.
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   ctrl_cmd, cond              - control word and condition field from ID
//   pc_in .. dest_in            - ID-stage operand/immediate values
//   hazard, flush, mem_freeze   - bubble, squash and global stall requests
//   status_we, status_in        - flag update from the EXE instruction
//   wb_en .. dest               - registered values for EXE
//   status                      - current NZCV register
//   bubble_cnt, flush_cnt       - saturating performance counters
module id_exe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [8:0]        ctrl_cmd,
  input  logic [3:0]        cond,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic              imm_in,
  input  logic [11:0]       shift_op_in,
  input  logic [23:0]       simm24_in,
  input  logic [3:0]        dest_in,
  input  logic              hazard,
  input  logic              flush,
  input  logic              mem_freeze,
  input  logic              status_we,
  input  logic [3:0]        status_in,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              b,
  output logic              s,
  output logic [3:0]        exe_cmd,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] val_rn,
  output logic [DATA_W-1:0] val_rm,
  output logic              imm,
  output logic [11:0]       shift_op,
  output logic [23:0]       simm24,
  output logic [3:0]        dest,
  output logic [3:0]        status,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  ctrl_t             r_ctrl;
  logic [DATA_W-1:0] r_pc, r_val_rn, r_val_rm;
  logic              r_imm;
  logic [11:0]       r_shift_op;
  logic [23:0]       r_simm24;
  logic [3:0]        r_dest;
  logic [3:0]        r_status;
  logic [CNT_W-1:0]  r_bubble_cnt, r_flush_cnt;

  logic [3:0]        w_eff_flags;
  logic              w_cond_pass;
  logic              w_bubble;

  // Bypass lets a conditional instruction directly behind a flag-setter see the new flags.
  assign w_eff_flags = status_we ? status_in : r_status;

  cond_check u_cond_check (
    .cond  (cond),
    .flags (w_eff_flags),
    .pass  (w_cond_pass)
  );

  assign w_bubble = hazard || !w_cond_pass;

  // Flag update is blocked only by a freeze; the flag setter is already past ID.
  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= '0;
    end else if (status_we && !mem_freeze) begin
      r_status <= status_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl       <= '0;
      r_pc         <= '0;
      r_val_rn     <= '0;
      r_val_rm     <= '0;
      r_imm        <= 1'b0;
      r_shift_op   <= '0;
      r_simm24     <= '0;
      r_dest       <= '0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else if (mem_freeze) begin
      // Hold everything; flush/hazard are re-sampled once the stall lifts.
    end else if (flush) begin
      r_ctrl     <= '0;
      r_pc       <= '0;
      r_val_rn   <= '0;
      r_val_rm   <= '0;
      r_imm      <= 1'b0;
      r_shift_op <= '0;
      r_simm24   <= '0;
      r_dest     <= '0;
      if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end else begin
      r_ctrl     <= w_bubble ? ctrl_t'('0) : ctrl_t'(ctrl_cmd);
      r_pc       <= pc_in;
      r_val_rn   <= val_rn_in;
      r_val_rm   <= val_rm_in;
      r_imm      <= imm_in;
      r_shift_op <= shift_op_in;
      r_simm24   <= simm24_in;
      r_dest     <= dest_in;
      if (w_bubble && (r_bubble_cnt != '1)) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign wb_en      = r_ctrl.wb_en;
  assign mem_r_en   = r_ctrl.mem_r_en;
  assign mem_w_en   = r_ctrl.mem_w_en;
  assign exe_cmd    = r_ctrl.exe_cmd;
  assign b          = r_ctrl.b;
  assign s          = r_ctrl.s;
  assign pc         = r_pc;
  assign val_rn     = r_val_rn;
  assign val_rm     = r_val_rm;
  assign imm        = r_imm;
  assign shift_op   = r_shift_op;
  assign simm24     = r_simm24;
  assign dest       = r_dest;
  assign status     = r_status;
  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_id_exe_reg.sv
// Directed self-checking bench for id_exe_reg.
module tb_id_exe_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  ctrl_cmd;
  logic [3:0]  cond;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic        imm_in;
  logic [11:0] shift_op_in;
  logic [23:0] simm24_in;
  logic [3:0]  dest_in;
  logic        hazard, flush, mem_freeze, status_we;
  logic [3:0]  status_in;
  logic        wb_en, mem_r_en, mem_w_en, b, s;
  logic [3:0]  exe_cmd;
  logic [31:0] pc, val_rn, val_rm;
  logic        imm;
  logic [11:0] shift_op;
  logic [23:0] simm24;
  logic [3:0]  dest;
  logic [3:0]  status;
  logic [15:0] bubble_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  localparam logic [8:0] CTRL_ADD = 9'h108;  // WB_EN=1, EXE_CMD=0010
  localparam logic [8:0] CTRL_MOV = 9'h104;  // WB_EN=1, EXE_CMD=0001
  localparam logic [8:0] CTRL_STR = 9'h048;  // MEM_W_EN=1, EXE_CMD=0010

  id_exe_reg #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_cmd(ctrl_cmd), .cond(cond),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .imm_in(imm_in), .shift_op_in(shift_op_in), .simm24_in(simm24_in),
    .dest_in(dest_in), .hazard(hazard), .flush(flush), .mem_freeze(mem_freeze),
    .status_we(status_we), .status_in(status_in),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .b(b), .s(s),
    .exe_cmd(exe_cmd), .pc(pc), .val_rn(val_rn), .val_rm(val_rm), .imm(imm),
    .shift_op(shift_op), .simm24(simm24), .dest(dest), .status(status),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land on the following falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; ctrl_cmd = '0; cond = 4'hE; pc_in = '0; val_rn_in = '0; val_rm_in = '0;
    imm_in = 1'b0; shift_op_in = '0; simm24_in = '0; dest_in = '0;
    hazard = 1'b0; flush = 1'b0; mem_freeze = 1'b0; status_we = 1'b0; status_in = '0;

    // Power-on reset state
    step();
    check("rst_ctrl", {wb_en, mem_r_en, mem_w_en, exe_cmd, b, s}, 0);
    check("rst_data", pc | val_rn | val_rm, 0);
    check("rst_status", status, 0);
    rst_n = 1'b1;

    // Load an all-ones control word and flags, then reset asynchronously mid-cycle
    ctrl_cmd = 9'h1FF; pc_in = 32'hABCD; val_rn_in = 32'h11; dest_in = 4'hF;
    imm_in = 1'b1; shift_op_in = 12'hFFF; simm24_in = 24'h123456;
    status_we = 1'b1; status_in = 4'hF;
    step();
    check("pre_rst_ctrl", {wb_en, mem_r_en, mem_w_en, exe_cmd, b, s}, 9'h1FF);
    check("pre_rst_status", status, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", {wb_en, mem_r_en, mem_w_en, exe_cmd, b, s}, 0);
    check("async_rst_data", {imm, dest, shift_op}, 0);
    check("async_rst_pc", pc, 0);
    check("async_rst_simm", simm24, 0);
    check("async_rst_status", status, 0);
    check("async_rst_cnts", {bubble_cnt, flush_cnt}, 0);
    ctrl_cmd = '0; status_we = 1'b0; status_in = '0; imm_in = 1'b0; shift_op_in = '0; simm24_in = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Pass-through ADD
    ctrl_cmd = CTRL_ADD; cond = 4'hE; pc_in = 32'h100; val_rn_in = 5; val_rm_in = 7; dest_in = 4'd3;
    step();
    check("add_wb_en", wb_en, 1);
    check("add_exe_cmd", exe_cmd, 4'b0010);
    check("add_rn", val_rn, 5);
    check("add_rm", val_rm, 7);
    check("add_pc_dest", {pc[15:0], dest}, {16'h100, 4'd3});
    check("add_bubble", bubble_cnt, 0);

    // Same-cycle flag bypass: EQ sees Z=1 from status_in
    ctrl_cmd = CTRL_MOV; cond = 4'h0; val_rn_in = 8; status_we = 1'b1; status_in = 4'b0100;
    step();
    check("eq_bypass_wb", wb_en, 1);
    check("eq_bypass_cmd", exe_cmd, 4'b0001);
    check("eq_status", status, 4'b0100);
    check("eq_bubble", bubble_cnt, 0);

    // NE with Z=1: bubble, data still loads
    cond = 4'h1; val_rn_in = 9;
    step();
    check("ne_ctrl", {wb_en, mem_r_en, mem_w_en, exe_cmd, b, s}, 0);
    check("ne_rn", val_rn, 9);
    check("ne_bubble", bubble_cnt, 1);
    status_we = 1'b0;

    // Flush and hazard together: only flush counts
    ctrl_cmd = CTRL_STR; cond = 4'hE; flush = 1'b1; hazard = 1'b1; val_rn_in = 11; pc_in = 32'h104;
    step();
    check("flush_mem_w", mem_w_en, 0);
    check("flush_data", pc | val_rn | val_rm, 0);
    check("flush_cnt", flush_cnt, 1);
    check("flush_bubble", bubble_cnt, 1);
    flush = 1'b0; hazard = 1'b0;

    // Freeze: load ADD, then hold for 3 cycles while inputs churn
    ctrl_cmd = CTRL_ADD; val_rn_in = 5; val_rm_in = 7; pc_in = 32'h200;
    step();
    check("frz_load_pc", pc, 32'h200);
    mem_freeze = 1'b1; flush = 1'b1; val_rn_in = 99; pc_in = 32'h300;
    status_we = 1'b1; status_in = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      step();
      check("frz_wb", wb_en, 1);
      check("frz_rn", val_rn, 5);
      check("frz_pc", pc, 32'h200);
      check("frz_cnts", {bubble_cnt, flush_cnt}, {16'd1, 16'd1});
      check("frz_status", status, 4'b0100);
      flush = ~flush;
    end
    mem_freeze = 1'b0; flush = 1'b0; status_we = 1'b0;
    step();
    check("unfrz_rn", val_rn, 99);
    check("unfrz_pc", pc, 32'h300);
    check("unfrz_wb", wb_en, 1);

    // Conditions against status = 0100 (Z=1, N=C=V=0)
    cond = 4'hD; step(); check("le_wb", wb_en, 1); check("le_bub", bubble_cnt, 1);
    cond = 4'hF; step(); check("nv_wb", wb_en, 0); check("nv_bub", bubble_cnt, 2);
    cond = 4'h8; step(); check("hi_wb", wb_en, 0); check("hi_bub", bubble_cnt, 3);
    cond = 4'hA; step(); check("ge_wb", wb_en, 1); check("ge_bub", bubble_cnt, 3);
    cond = 4'hC; step(); check("gt_wb", wb_en, 0); check("gt_bub", bubble_cnt, 4);

    // Saturation of bubble_cnt from a fresh reset
    cond = 4'hE;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hazard = 1'b1;
    repeat (16'hFFFE) @(posedge clk);
    @(negedge clk);
    check("sat_fffe", bubble_cnt, 16'hFFFE);
    step();
    check("sat_ffff", bubble_cnt, 16'hFFFF);
    step(); step(); step();
    check("sat_hold", bubble_cnt, 16'hFFFF);
    check("sat_flush", flush_cnt, 0);
    check("sat_ctrl", wb_en, 0);
    hazard = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
